irq_ctrl: RTL

Memory-mapped interrupt controller that sits directly downstream of the timer/counters and the external interrupt pin and feeds the CP0 hardware-interrupt field. It samples six interrupt request lines, latches them as level or edge events, applies a per-source mask and a global enable, and presents the result to CP0 as `HWInt[5:0]`. The CPU programs and services it through the system bridge with the same word-addressed `Addr`/`WE`/`Din`/`Dout` bus used by the timers.

---
 rtl/irq_ctrl.sv | 52 +++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source level/edge interrupt latch with mask, global enable and priority status.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [5:0]  irq_in,
  output logic [5:0]  HWInt
);
  logic [5:0] mask, mode, pend, ovr, s_q, rise, pclr, mchg, sclr, oset, active;
  logic       ge, any;
  logic [2:0] idx;
  logic [1:0] sel;
  logic       unused;
  assign unused = ^{Addr[31:4], Din[31:9], Din[7:6]};
  assign sel    = Addr[3:2];
  assign rise   = irq_in & ~s_q;
  assign pclr   = (WE && sel == 2'd2) ? (Din[5:0] & mode) : 6'd0;
  assign mchg   = (WE && sel == 2'd1) ? (Din[5:0] ^ mode) : 6'd0;
  assign sclr   = (WE && sel == 2'd3) ? Din[5:0] : 6'd0;
  // an edge on an already-pending source that is not being serviced this cycle is lost
  assign oset   = mode & rise & pend & ~pclr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mask <= '0;
      ge   <= 1'b0;
      mode <= '0;
      pend <= '0;
      ovr  <= '0;
      s_q  <= '0;
    end else begin
      s_q  <= irq_in;
      pend <= ~mchg & ((mode & (rise | (pend & ~pclr))) | (~mode & irq_in));
      ovr  <= ~mchg & (oset | (ovr & ~sclr));
      if (WE && sel == 2'd0) begin
        mask <= Din[5:0];
        ge   <= Din[8];
      end
      if (WE && sel == 2'd1) mode <= Din[5:0];
    end
  assign active = pend & mask & {6{ge}};
  assign HWInt  = active;
  assign any    = |active;
  assign idx    = active[0] ? 3'd0 : active[1] ? 3'd1 : active[2] ? 3'd2 :
                  active[3] ? 3'd3 : active[4] ? 3'd4 : active[5] ? 3'd5 : 3'd0;
  assign Dout   = sel == 2'd0 ? {23'd0, ge, 2'd0, mask} :
                  sel == 2'd1 ? {26'd0, mode} :
                  sel == 2'd2 ? {26'd0, pend} :
                                {20'd0, any, idx, 2'd0, ovr};
endmodule
